// File: rtl/jtframe_cen_frac_multi_pkg.sv
// Shared helpers for the fractional clock-enable generator.
// Channel-select width derivation used by the top and its users.
package jtframe_cen_frac_multi_pkg;

  function automatic int chw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtframe_cen_frac_ch.sv
// One fractional enable channel: n/m rate cen plus half-phase cenb.
// Holds its own ratio, accumulator and registered strobes.
module jtframe_cen_frac_ch #(
  parameter int W     = 8,
  parameter int DEF_N = 1,
  parameter int DEF_M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_n,
  input  logic [W-1:0] i_m,
  input  logic         i_resync,
  input  logic         i_pause,
  output logic         o_cen,
  output logic         o_cenb
);

  localparam logic [W-1:0] LN = W'(DEF_N);
  localparam logic [W-1:0] LM = W'(DEF_M);

  logic [W-1:0] r_n;
  logic [W-1:0] r_m;
  logic [W-1:0] r_acc;
  logic [W:0]   w_sum;
  logic [W-1:0] w_half;
  logic         w_off;
  logic         w_full;
  logic         w_wrap;
  logic         w_half_hit;

  assign w_sum      = {1'b0, r_acc} + {1'b0, r_n};
  assign w_half     = r_m >> 1;
  assign w_off      = (r_m == '0) || (r_n == '0);
  assign w_full     = r_n >= r_m;
  assign w_wrap     = w_sum >= {1'b0, r_m};
  assign w_half_hit = (r_acc < w_half) &&
                      (w_sum >= {1'b0, w_half}) &&
                      (w_half != '0);

  // Ratio registers, accumulator and strobes; resync beats load beats pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n    <= LN;
      r_m    <= LM;
      r_acc  <= '0;
      o_cen  <= 1'b0;
      o_cenb <= 1'b0;
    end else if (i_resync) begin
      r_acc  <= '0;
      o_cen  <= 1'b0;
      o_cenb <= 1'b0;
    end else if (i_load) begin
      r_n    <= i_n;
      r_m    <= i_m;
      r_acc  <= '0;
      o_cen  <= 1'b0;
      o_cenb <= 1'b0;
    end else if (i_pause) begin
      o_cen  <= 1'b0;
      o_cenb <= 1'b0;
    end else if (w_off) begin
      r_acc  <= '0;
      o_cen  <= 1'b0;
      o_cenb <= 1'b0;
    end else if (w_full) begin
      r_acc  <= '0;
      o_cen  <= 1'b1;
      o_cenb <= 1'b0;
    end else if (w_wrap) begin
      // sum < 2m here, so the wrapped value always fits in W bits
      r_acc  <= r_acc + r_n - r_m;
      o_cen  <= 1'b1;
      o_cenb <= 1'b0;
    end else begin
      r_acc  <= w_sum[W-1:0];
      o_cen  <= 1'b0;
      o_cenb <= w_half_hit;
    end
  end

endmodule

// File: rtl/jtframe_cen_frac_multi.sv
// Multi-channel fractional clock-enable generator.
// Decodes config writes per channel, broadcasts resync and pause.
module jtframe_cen_frac_multi
  import jtframe_cen_frac_multi_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int W     = 8,
  parameter  int DEF_N = 1,
  parameter  int DEF_M = 2,
  localparam int CHW   = chw_of(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_n,
  input  logic [W-1:0]   cfg_m,
  input  logic           resync,
  input  logic           pause,
  output logic [NCH-1:0] cen,
  output logic [NCH-1:0] cenb
);

  logic [NCH-1:0] w_load;

  // Per-channel load strobes; out-of-range indices match nothing
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NCH; i++) begin
      w_load[i] = cfg_we && (cfg_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    jtframe_cen_frac_ch #(
      .W     (W),
      .DEF_N (DEF_N),
      .DEF_M (DEF_M)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load[g]),
      .i_n      (cfg_n),
      .i_m      (cfg_m),
      .i_resync (resync),
      .i_pause  (pause),
      .o_cen    (cen[g]),
      .o_cenb   (cenb[g])
    );
  end

endmodule

// File: tb/tb_jtframe_cen_frac_multi.sv
// Bench for jtframe_cen_frac_multi: reference model scoreboard,
// ratio table with pulse counts, resync/pause and reset sequences.
module tb_jtframe_cen_frac_multi;
  import jtframe_cen_frac_multi_pkg::*;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int CHW  = chw_of(NCH);
  localparam int NCH3 = 3;
  localparam int CHW3 = chw_of(NCH3);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [W-1:0]    cfg_n = '0;
  logic [W-1:0]    cfg_m = '0;
  logic            resync = 1'b0;
  logic            pause = 1'b0;
  logic [NCH-1:0]  cen;
  logic [NCH-1:0]  cenb;
  logic [CHW3-1:0] cfg_ch3 = CHW3'(3);
  logic [NCH3-1:0] cen3;
  logic [NCH3-1:0] cenb3;

  jtframe_cen_frac_multi #(.NCH(NCH), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .resync(resync), .pause(pause),
    .cen(cen), .cenb(cenb)
  );

  // 3-channel copy: every write aims at index 3, which does not exist
  jtframe_cen_frac_multi #(.NCH(NCH3), .W(W)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch3),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .resync(1'b0), .pause(1'b0),
    .cen(cen3), .cenb(cenb3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    bit c;
    bit b;
  } st_t;

  typedef struct packed {
    logic [NCH-1:0]  c;
    logic [NCH-1:0]  b;
    logic [NCH3-1:0] c3;
    logic [NCH3-1:0] b3;
  } exp_t;

  typedef struct {
    bit wr;
    int ch;
    int n;
    int m;
    int cyc;
    int ncen;
    int ncenb;
  } vec_t;

  int   ncmp = 0;
  int   nerr = 0;
  int   ntick = 0;
  int   mn[NCH];
  int   mm[NCH];
  int   macc[NCH];
  int   xacc;
  exp_t q[$];
  logic [NCH-1:0] lc;
  logic [NCH-1:0] lb;

  function automatic st_t step(input int n, input int m, input int acc);
    st_t r;
    int h;
    h = m / 2;
    r.acc = 0; r.c = 0; r.b = 0;
    if (m == 0 || n == 0) begin
      r.acc = 0;
    end else if (n >= m) begin
      r.c = 1;
    end else if (acc + n >= m) begin
      r.acc = acc + n - m;
      r.c = 1;
    end else begin
      r.acc = acc + n;
      r.b = (acc < h) && (acc + n >= h) && (h != 0);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mn[i] = 1; mm[i] = 2; macc[i] = 0;
    end
    xacc = 0;
  endtask

  task automatic tick(input bit we, input int ch, input int n,
                      input int m, input bit rs, input bit ps);
    exp_t e;
    st_t  s;
    cfg_we = we;
    cfg_ch = CHW'(ch);
    cfg_n  = W'(n);
    cfg_m  = W'(m);
    resync = rs;
    pause  = ps;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rs) begin
        macc[i] = 0;
      end else if (we && ch == i) begin
        mn[i] = n; mm[i] = m; macc[i] = 0;
      end else if (!ps) begin
        s = step(mn[i], mm[i], macc[i]);
        macc[i] = s.acc;
        e.c[i] = s.c;
        e.b[i] = s.b;
      end
    end
    s = step(1, 2, xacc);
    xacc = s.acc;
    e.c3 = {NCH3{s.c}};
    e.b3 = {NCH3{s.b}};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    ntick++;
    lc = cen;
    lb = cenb;
    ncmp++;
    if ({cen, cenb, cen3, cenb3} !== e) begin
      nerr++;
      $display("FAIL tick%0d cen=%b cenb=%b cen3=%b cenb3=%b want %b %b %b %b",
               ntick, cen, cenb, cen3, cenb3, e.c, e.b, e.c3, e.b3);
    end
    cfg_we = 1'b0;
    resync = 1'b0;
    pause  = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int kc;
    int kb;
    vt[0] = '{wr:0, ch:0, n:1, m:2,  cyc:50, ncen:25, ncenb:25};
    vt[1] = '{wr:1, ch:1, n:5, m:12, cyc:12, ncen:5,  ncenb:5};
    vt[2] = '{wr:1, ch:2, n:1, m:13, cyc:26, ncen:2,  ncenb:2};
    vt[3] = '{wr:1, ch:3, n:7, m:7,  cyc:10, ncen:10, ncenb:0};
    vt[4] = '{wr:1, ch:3, n:0, m:9,  cyc:10, ncen:0,  ncenb:0};
    vt[5] = '{wr:1, ch:3, n:7, m:0,  cyc:10, ncen:0,  ncenb:0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    ncmp++;
    if (cen !== '0 || cenb !== '0 || cen3 !== '0 || cenb3 !== '0) begin
      nerr++;
      $display("FAIL reset_out cen=%b cenb=%b want 0", cen, cenb);
    end
    rst_n = 1'b1;

    // ratio table: per-cycle model check plus absolute pulse counts
    for (int v = 0; v < 6; v++) begin
      if (vt[v].wr) tick(1, vt[v].ch, vt[v].n, vt[v].m, 0, 0);
      kc = 0;
      kb = 0;
      for (int c = 0; c < vt[v].cyc; c++) begin
        tick(0, 0, 0, 0, 0, 0);
        kc += int'(lc[vt[v].ch]);
        kb += int'(lb[vt[v].ch]);
      end
      ncmp++;
      if (kc != vt[v].ncen || kb != vt[v].ncenb) begin
        nerr++;
        $display("FAIL vec%0d counts cen=%0d cenb=%0d want %0d %0d",
                 v, kc, kb, vt[v].ncen, vt[v].ncenb);
      end
    end

    // staggered phases, then resync under pause, then release
    tick(1, 0, 1, 3, 0, 0);
    idle(1);
    tick(1, 1, 1, 3, 0, 0);
    tick(1, 2, 1, 3, 0, 0);
    tick(1, 3, 3, 7, 0, 0);
    idle(2);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 1);
    ncmp++;
    if (cen !== '0 || cenb !== '0) begin
      nerr++;
      $display("FAIL resync_out cen=%b cenb=%b want 0", cen, cenb);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      ncmp++;
      if (lc[0] !== lc[1] || lc[1] !== lc[2]) begin
        nerr++;
        $display("FAIL aligned cyc%0d cen=%b want equal ch0..2", i, lc);
      end
    end

    // pause mid-period preserves phase
    idle(1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 1);
    idle(8);

    // async reset mid-run with ch3 stuck high
    tick(1, 3, 7, 7, 0, 0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (cen !== '0 || cenb !== '0 || cen3 !== '0) begin
      nerr++;
      $display("FAIL async_rst cen=%b cenb=%b want 0", cen, cenb);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
